// File: rtl/local_history_predictor.sv
// Local history predictor: six saturating jump-status counters, one per
// conditional branch type. It keeps ID/EX snapshots so that squashes and mispredictions can roll the counters back.
module local_history_predictor #(
  parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
  parameter int COUNTER_INIT_VALUE        = (1 << (JUMP_STATUS_COUNTER_WIDTH - 1)) - 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall,
  input  logic                                 prediction_en,
  input  logic                                 beq,
  input  logic                                 bne,
  input  logic                                 blt,
  input  logic                                 bge,
  input  logic                                 bltu,
  input  logic                                 bgeu,
  input  logic                                 prediction_result,
  input  logic                                 rollback_en_id,
  input  logic                                 rollback_en_ex,
  input  logic                                 prediction_result_branch_failed,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_beq_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bne_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_blt_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bge_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bltu_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bgeu_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_beq_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bne_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_blt_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bge_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bltu_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bgeu_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_beq_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bne_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_blt_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bge_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bltu_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_bgeu_count_ex,
  output logic                                 prediction_result_id
);

  localparam int W = JUMP_STATUS_COUNTER_WIDTH;
  localparam logic [W-1:0] INIT = COUNTER_INIT_VALUE[W-1:0];
  localparam logic [W-1:0] MAX  = {W{1'b1}};

  // Index order in every set and tag: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu.
  typedef logic [5:0][W-1:0] set_t;

  function automatic set_t upd(input set_t s, input logic [5:0] tag, input logic dir);
    set_t r;
    r = s;
    for (int i = 0; i < 6; i++) begin
      if (tag[i]) begin
        if (dir) begin
          if (s[i] != MAX) r[i] = s[i] + 1'b1;
        end else begin
          if (s[i] != '0) r[i] = s[i] - 1'b1;
        end
      end
    end
    return r;
  endfunction

  set_t       cnt;
  set_t       pre_id;
  set_t       pre_ex;
  logic [5:0] tag_id;
  logic [5:0] tag_ex;
  logic       pred_id;

  // prediction_en is the valid for the IF branch type and prediction_result in
  // the same cycle; there is no back-pressure, PL_stall only freezes state.
  logic [5:0] if_tag;
  set_t       if_next;
  set_t       r_ex;
  set_t       r_id;

  assign if_tag  = prediction_en ? {bgeu, bltu, bge, blt, bne, beq} : 6'b0;
  assign if_next = upd(cnt, if_tag, prediction_result);
  assign r_ex    = upd(pre_ex, tag_ex, prediction_result_branch_failed);
  assign r_id    = upd(pre_id, tag_id, pred_id);

  // The EX prediction is never consumed: the EX restore uses the corrected direction instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= {6{INIT}};
      pre_id  <= {6{INIT}};
      pre_ex  <= {6{INIT}};
      tag_id  <= '0;
      tag_ex  <= '0;
      pred_id <= 1'b0;
    end else if (rollback_en_ex) begin
      cnt     <= r_ex;
      pre_id  <= r_ex;
      pre_ex  <= r_ex;
      tag_id  <= '0;
      tag_ex  <= '0;
      pred_id <= 1'b0;
    end else if (rollback_en_id) begin
      cnt     <= r_id;
      pre_ex  <= pre_id;
      tag_ex  <= tag_id;
      pre_id  <= r_id;
      tag_id  <= '0;
    end else if (!PL_stall) begin
      cnt     <= if_next;
      pre_id  <= cnt;
      tag_id  <= if_tag;
      pred_id <= prediction_result;
      pre_ex  <= pre_id;
      tag_ex  <= tag_id;
    end
  end

  assign LHP_beq_count     = cnt[0];
  assign LHP_bne_count     = cnt[1];
  assign LHP_blt_count     = cnt[2];
  assign LHP_bge_count     = cnt[3];
  assign LHP_bltu_count    = cnt[4];
  assign LHP_bgeu_count    = cnt[5];
  assign LHP_beq_count_id  = pre_id[0];
  assign LHP_bne_count_id  = pre_id[1];
  assign LHP_blt_count_id  = pre_id[2];
  assign LHP_bge_count_id  = pre_id[3];
  assign LHP_bltu_count_id = pre_id[4];
  assign LHP_bgeu_count_id = pre_id[5];
  assign LHP_beq_count_ex  = pre_ex[0];
  assign LHP_bne_count_ex  = pre_ex[1];
  assign LHP_blt_count_ex  = pre_ex[2];
  assign LHP_bge_count_ex  = pre_ex[3];
  assign LHP_bltu_count_ex = pre_ex[4];
  assign LHP_bgeu_count_ex = pre_ex[5];
  assign prediction_result_id = pred_id;

endmodule

// File: tb/tb_local_history_predictor.sv
// Directed bench for local_history_predictor; expected counter sets are hand-computed,
// packed as {bgeu,bltu,bge,blt,bne,beq} with 2 bits each (01 everywhere = 12'h555).
module tb_local_history_predictor;

  logic clk;
  logic rst_n;
  logic PL_stall, prediction_en, prediction_result;
  logic beq, bne, blt, bge, bltu, bgeu;
  logic rollback_en_id, rollback_en_ex, prediction_result_branch_failed;
  logic [1:0] c_beq, c_bne, c_blt, c_bge, c_bltu, c_bgeu;
  logic [1:0] i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu;
  logic [1:0] e_beq, e_bne, e_blt, e_bge, e_bltu, e_bgeu;
  logic pred_id_out;

  int tests_run = 0;
  int tests_failed = 0;

  logic [36:0] exp_q[$];
  string       name_q[$];

  local_history_predictor dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .prediction_en(prediction_en),
    .beq(beq), .bne(bne), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
    .prediction_result(prediction_result), .rollback_en_id(rollback_en_id),
    .rollback_en_ex(rollback_en_ex),
    .prediction_result_branch_failed(prediction_result_branch_failed),
    .LHP_beq_count(c_beq), .LHP_bne_count(c_bne), .LHP_blt_count(c_blt),
    .LHP_bge_count(c_bge), .LHP_bltu_count(c_bltu), .LHP_bgeu_count(c_bgeu),
    .LHP_beq_count_id(i_beq), .LHP_bne_count_id(i_bne), .LHP_blt_count_id(i_blt),
    .LHP_bge_count_id(i_bge), .LHP_bltu_count_id(i_bltu), .LHP_bgeu_count_id(i_bgeu),
    .LHP_beq_count_ex(e_beq), .LHP_bne_count_ex(e_bne), .LHP_blt_count_ex(e_blt),
    .LHP_bge_count_ex(e_bge), .LHP_bltu_count_ex(e_bltu), .LHP_bgeu_count_ex(e_bgeu),
    .prediction_result_id(pred_id_out)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [36:0] actual_vec();
    return {c_bgeu, c_bltu, c_bge, c_blt, c_bne, c_beq,
            i_bgeu, i_bltu, i_bge, i_blt, i_bne, i_beq,
            e_bgeu, e_bltu, e_bge, e_blt, e_bne, e_beq, pred_id_out};
  endfunction

  task automatic compare(input string nm, input logic [36:0] act, input logic [36:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got cnt=%h id=%h ex=%h pred_id=%b, expected cnt=%h id=%h ex=%h pred_id=%b",
               nm, act[36:25], act[24:13], act[12:1], act[0],
               exp[36:25], exp[24:13], exp[12:1], exp[0]);
    end
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      compare(name_q.pop_front(), actual_vec(), exp_q.pop_front());
    end
  end

  task automatic clear_inputs();
    {bgeu, bltu, bge, blt, bne, beq} = 6'b0;
    prediction_en = 1'b0; prediction_result = 1'b0; PL_stall = 1'b0;
    rollback_en_id = 1'b0; rollback_en_ex = 1'b0; prediction_result_branch_failed = 1'b0;
  endtask

  // ty is {bgeu,bltu,bge,blt,bne,beq}; the expected state is the one after this edge.
  task automatic step(input string nm, input logic [5:0] ty, input logic en, input logic pr,
                      input logic st, input logic rid, input logic rex, input logic bf,
                      input logic [11:0] ec, input logic [11:0] ei, input logic [11:0] ee,
                      input logic ep);
    @(negedge clk);
    {bgeu, bltu, bge, blt, bne, beq} = ty;
    prediction_en = en; prediction_result = pr; PL_stall = st;
    rollback_en_id = rid; rollback_en_ex = rex; prediction_result_branch_failed = bf;
    exp_q.push_back({ec, ei, ee, ep});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic pulse_reset(input string nm);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    compare(nm, actual_vec(), {12'h555, 12'h555, 12'h555, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 compare("reset_initial", actual_vec(), {12'h555, 12'h555, 12'h555, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // beq taken three times: 01 -> 10 -> 11 -> 11
    step("beq_t1", 6'b000001, 1, 1, 0, 0, 0, 0, 12'h556, 12'h555, 12'h555, 1);
    step("beq_t2", 6'b000001, 1, 1, 0, 0, 0, 0, 12'h557, 12'h556, 12'h555, 1);
    step("beq_sat", 6'b000001, 1, 1, 0, 0, 0, 0, 12'h557, 12'h557, 12'h556, 1);
    step("beq_idle", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h557, 12'h557, 12'h557, 0);
    pulse_reset("reset_mid_cycle");

    // bltu not-taken, then stalled, then saturation at zero
    step("bltu_nt", 6'b010000, 1, 0, 0, 0, 0, 0, 12'h455, 12'h555, 12'h555, 0);
    step("bltu_stall", 6'b010000, 1, 0, 1, 0, 0, 0, 12'h455, 12'h555, 12'h555, 0);
    step("bltu_idle1", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h455, 12'h455, 12'h555, 0);
    step("bltu_idle2", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h455, 12'h455, 12'h455, 0);
    step("bltu_floor", 6'b010000, 1, 0, 0, 0, 0, 0, 12'h455, 12'h455, 12'h455, 0);
    pulse_reset("reset_after_bltu");

    // bne taken, EX misprediction two cycles later with actual not-taken
    step("bne_t", 6'b000010, 1, 1, 0, 0, 0, 0, 12'h559, 12'h555, 12'h555, 1);
    step("bne_idle", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h559, 12'h559, 12'h555, 0);
    step("bne_rb_ex", 6'b000001, 1, 1, 0, 0, 1, 0, 12'h551, 12'h551, 12'h551, 0);
    step("bne_after", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h551, 12'h551, 12'h551, 0);
    pulse_reset("reset_after_bne");

    // blt taken, then bge taken squashed by an ID redirect in the same cycle
    step("blt_t", 6'b000100, 1, 1, 0, 0, 0, 0, 12'h565, 12'h555, 12'h555, 1);
    step("bge_rb_id", 6'b001000, 1, 1, 0, 1, 0, 0, 12'h565, 12'h565, 12'h555, 1);
    step("rb_id_after", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h565, 12'h565, 12'h565, 0);
    pulse_reset("reset_after_blt");

    // Both rollbacks under stall: EX restore wins, tags cleared
    step("beq_t", 6'b000001, 1, 1, 0, 0, 0, 0, 12'h556, 12'h555, 12'h555, 1);
    step("bne_t2", 6'b000010, 1, 1, 0, 0, 0, 0, 12'h55A, 12'h556, 12'h555, 1);
    step("rb_both", 6'b000000, 0, 0, 1, 1, 1, 1, 12'h556, 12'h556, 12'h556, 0);
    step("rb_both_idle", 6'b000000, 0, 0, 0, 0, 0, 0, 12'h556, 12'h556, 12'h556, 0);
    step("rb_ex_empty", 6'b000000, 0, 0, 0, 0, 1, 0, 12'h556, 12'h556, 12'h556, 0);

    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
